// File: rtl/ai_agent_pkg.sv
// Shared constants for the ai_agent_seq move selector: cell codes, score weights,
// FSM state encoding and the tie-break LFSR configuration.
package ai_agent_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_AI     = 2'b10;

  localparam logic [3:0] W_BASE   = 4'd1;
  localparam logic [3:0] W_WIN    = 4'd8;
  localparam logic [3:0] W_BLOCK  = 4'd4;
  localparam logic [3:0] W_CENTER = 4'd2;
  localparam logic [3:0] W_CORNER = 4'd1;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StScan = 2'd1;
  localparam state_t StDone = 2'd2;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting towards the MSB
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ai_cell_eval.sv
// Combinational scorer for one candidate cell: win/block on every line through the
// cell, plus centre and corner bonuses. Occupied cells score 0.
module ai_cell_eval
  import ai_agent_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned IDXW = $clog2(N * N)
) (
  input  logic [2*N*N-1:0] board_i,
  input  logic [IDXW-1:0]  idx_i,
  output logic [3:0]       score_o
);

  localparam int unsigned BW = $clog2(2 * N * N);

  int unsigned idx_n, row, col;
  logic [1:0]  c;
  logic        row_win, row_blk, col_win, col_blk;
  logic        dia_win, dia_blk, ant_win, ant_blk;
  logic        win, blk, is_centre, is_corner, empty;

  always_comb begin
    idx_n   = 32'(idx_i);
    row     = idx_n / N;
    col     = idx_n % N;
    c       = CELL_EMPTY;
    row_win = 1'b1;
    row_blk = 1'b1;
    col_win = 1'b1;
    col_blk = 1'b1;
    dia_win = 1'b1;
    dia_blk = 1'b1;
    ant_win = 1'b1;
    ant_blk = 1'b1;
    // The candidate itself is excluded: a line wins/blocks when all other cells match.
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned k = 0; k < N; k++) begin
        if ((r * N + k) != idx_n) begin
          c = board_i[BW'(2 * (r * N + k)) +: 2];
          if (r == row) begin
            row_win &= (c == CELL_AI);
            row_blk &= (c == CELL_PLAYER);
          end
          if (k == col) begin
            col_win &= (c == CELL_AI);
            col_blk &= (c == CELL_PLAYER);
          end
          if (r == k) begin
            dia_win &= (c == CELL_AI);
            dia_blk &= (c == CELL_PLAYER);
          end
          if (r + k == N - 1) begin
            ant_win &= (c == CELL_AI);
            ant_blk &= (c == CELL_PLAYER);
          end
        end
      end
    end
    win = row_win | col_win | ((row == col) & dia_win) | ((row + col == N - 1) & ant_win);
    blk = row_blk | col_blk | ((row == col) & dia_blk) | ((row + col == N - 1) & ant_blk);
    is_centre = ((N % 2) == 1) && (idx_n == (N * N - 1) / 2);
    is_corner = (idx_n == 0) || (idx_n == N - 1) || (idx_n == N * N - N) ||
                (idx_n == N * N - 1);
    empty = (board_i[BW'(2 * idx_n) +: 2] == CELL_EMPTY);
    score_o = empty ? (W_BASE + (win ? W_WIN : 4'd0) + (blk ? W_BLOCK : 4'd0) +
                       (is_centre ? W_CENTER : 4'd0) + (is_corner ? W_CORNER : 4'd0))
                    : 4'd0;
  end

endmodule

// File: rtl/ai_agent_seq.sv
// Sequential AI move selector: scans one cell per clock and reports the best move.
// Optional macro AI_TIEBREAK_LFSR_EN randomises equal-score tie-breaks with an LFSR.
module ai_agent_seq
  import ai_agent_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned IDXW = $clog2(N * N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N*N-1:0] cell_position,
  output logic [IDXW-1:0]  ai_tick,
  output logic             done,
  output logic             busy,
  output logic             no_move,
  output logic [3:0]       best_score
);

  localparam logic [IDXW-1:0] LastIdx = IDXW'(N * N - 1);

  state_t           state_q, state_d;
  logic [2*N*N-1:0] board_q, board_d;
  logic [IDXW-1:0]  idx_q, idx_d, best_idx_q, best_idx_d, ai_tick_q, ai_tick_d;
  logic [3:0]       run_best_q, run_best_d, best_score_q, best_score_d;
  logic             found_q, found_d, done_q, done_d, busy_q, busy_d;
  logic             no_move_q, no_move_d;
  logic [3:0]       score;
  logic             tie_take;

  ai_cell_eval #(
    .N    (N),
    .IDXW (IDXW)
  ) u_eval (
    .board_i (board_q),
    .idx_i   (idx_q),
    .score_o (score)
  );

`ifdef AI_TIEBREAK_LFSR_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_next(lfsr_q);
  end

  assign tie_take = (score == run_best_q) && (score != 4'd0) && lfsr_q[0];
`else
  assign tie_take = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    run_best_d   = run_best_q;
    found_d      = found_q;
    ai_tick_d    = ai_tick_q;
    best_score_d = best_score_q;
    no_move_d    = no_move_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          board_d    = cell_position;
          idx_d      = '0;
          best_idx_d = '0;
          run_best_d = 4'd0;
          found_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = StScan;
        end
      end
      StScan: begin
        // Strict > keeps the lowest index on ties unless the LFSR overrides.
        if ((score > run_best_q) || tie_take) begin
          run_best_d = score;
          best_idx_d = idx_q;
          found_d    = 1'b1;
        end
        if (idx_q == LastIdx) state_d = StDone;
        else                  idx_d   = idx_q + 1'b1;
      end
      StDone: begin
        done_d       = 1'b1;
        busy_d       = 1'b0;
        ai_tick_d    = found_q ? best_idx_q : '0;
        best_score_d = found_q ? run_best_q : 4'd0;
        no_move_d    = ~found_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      board_q      <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      run_best_q   <= 4'd0;
      found_q      <= 1'b0;
      ai_tick_q    <= '0;
      best_score_q <= 4'd0;
      no_move_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      run_best_q   <= run_best_d;
      found_q      <= found_d;
      ai_tick_q    <= ai_tick_d;
      best_score_q <= best_score_d;
      no_move_q    <= no_move_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ai_tick    = ai_tick_q;
  assign best_score = best_score_q;
  assign no_move    = no_move_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ai_agent_seq.sv
// Self-checking bench for ai_agent_seq: table of N=3 boards with a result scoreboard,
// plus sequences for ignored start, mid-scan reset and an N=4 instance.
module tb_ai_agent_seq;

  localparam int unsigned N    = 3;
  localparam int unsigned C    = N * N;
  localparam int unsigned IDXW = $clog2(C);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [2*C-1:0]  cp = '0;
  logic [IDXW-1:0] ai_tick;
  logic            done, busy, no_move;
  logic [3:0]      best_score;

  logic            start4 = 1'b0;
  logic [31:0]     cp4 = '0;
  logic [3:0]      ai_tick4;
  logic            done4, busy4, no_move4;
  logic [3:0]      best_score4;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] tick;
    logic [3:0] score;
    logic       nm;
  } exp_t;

  typedef struct packed {
    logic [2*C-1:0] brd;
    exp_t           e;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  ai_agent_seq #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cell_position (cp),
    .ai_tick       (ai_tick),
    .done          (done),
    .busy          (busy),
    .no_move       (no_move),
    .best_score    (best_score)
  );

  ai_agent_seq #(.N(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .start         (start4),
    .cell_position (cp4),
    .ai_tick       (ai_tick4),
    .done          (done4),
    .busy          (busy4),
    .no_move       (no_move4),
    .best_score    (best_score4)
  );

  // A = AI, P = player, X = invalid, anything else empty; char i is cell i
  function automatic logic [2*C-1:0] mk(input string s);
    logic [2*C-1:0] r;
    byte ch;
    r = '0;
    for (int i = 0; i < int'(C); i++) begin
      ch = s[i];
      if (ch == "A")      r[2*i +: 2] = 2'b10;
      else if (ch == "P") r[2*i +: 2] = 2'b01;
      else if (ch == "X") r[2*i +: 2] = 2'b11;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_result(input exp_t e);
    chk("ai_tick", int'(ai_tick), int'(e.tick));
    chk("best_score", int'(best_score), int'(e.score));
    chk("no_move", int'(no_move), int'(e.nm));
  endtask

  task automatic run_n3(input logic [2*C-1:0] brd, input exp_t e);
    int   n;
    bit   seen;
    exp_t got;
    @(negedge clk);
    cp    = brd;
    start = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    cp    = '1;  // board must already be latched
    chk("busy_rise", int'(busy), 1);
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1;
    end
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("latency", n, int'(C) + 1);
      got = sbq.pop_front();
      compare_result(got);
      chk("busy_fall", int'(busy), 0);
      @(posedge clk);
      #1;
      chk("done_pulse", int'(done), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("tick_hold", int'(ai_tick), int'(got.tick));
    end else begin
      sbq.delete();
    end
  endtask

  initial begin
    int   n;
    int   dones;
    exp_t got;
    logic [3:0] t4;

    vecs[0] = '{mk("........."), '{4'd4, 4'd3, 1'b0}};
    vecs[1] = '{mk("AA.PP...."), '{4'd2, 4'd10, 1'b0}};
    vecs[2] = '{mk("PP..A...."), '{4'd2, 4'd6, 1'b0}};
    vecs[3] = '{mk("AA...P..P"), '{4'd2, 4'd14, 1'b0}};
    vecs[4] = '{mk("A.......A"), '{4'd4, 4'd11, 1'b0}};
    vecs[5] = '{mk("..P.P...."), '{4'd6, 4'd6, 1'b0}};
    vecs[6] = '{mk("APAPAPPA."), '{4'd8, 4'd10, 1'b0}};
    vecs[7] = '{mk("....A...."), '{4'd0, 4'd2, 1'b0}};
    vecs[8] = '{mk("APAPAPPAP"), '{4'd0, 4'd0, 1'b1}};

    repeat (2) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_no_move", int'(no_move), 0);
    chk("rst_ai_tick", int'(ai_tick), 0);
    chk("rst_best_score", int'(best_score), 0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_n3(vecs[i].brd, vecs[i].e);

    // Full invalid board; a second start mid-scan must not queue another decision
    @(negedge clk);
    cp    = mk("XXXXXXXXX");
    start = 1'b1;
    sbq.push_back('{4'd0, 4'd0, 1'b1});
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) start = 1'b1;
      if (n == 4) start = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) begin
          chk("full_latency", n, int'(C) + 1);
          got = sbq.pop_front();
          compare_result(got);
        end
      end
    end
    chk("full_single_done", dones, 1);
    sbq.delete();

    // Reset in the middle of a scan aborts it silently
    @(negedge clk);
    cp    = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_tick", int'(ai_tick), 0);
    @(negedge clk);
    rst   = 1'b1;
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_n3(mk("........."), '{4'd4, 4'd3, 1'b0});

    // N=4 empty board: all four corners tie at score 2
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("n4_done_seen", int'(done4), 1);
    chk("n4_latency", n, 17);
    t4 = ai_tick4;
    chk("n4_corner", int'(t4 == 4'd0 || t4 == 4'd3 || t4 == 4'd12 || t4 == 4'd15), 1);
`ifndef AI_TIEBREAK_LFSR_EN
    chk("n4_tick", int'(ai_tick4), 0);
`endif
    chk("n4_score", int'(best_score4), 2);
    chk("n4_no_move", int'(no_move4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ai_agent_seq.md
Name: ai_agent_seq

Overview:
Parametrised, multi-cycle successor to the tic-tac-toe AI move selector, for an N x N board.
- Visits one candidate cell per clock and scores it with line-aware rules: win completion, opponent block, centre bonus and corner bonus.
- Returns the best move index with a one-cycle done pulse.
- Sits between the game controller, which asserts start on the AI's turn, and the board register that applies ai_tick.

Parameters:
- N, 3: board side length. Legal range 3..8. Cells = N*N.
- IDXW, $clog2(N*N): width of the cell index. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a decision. Sampled only in IDLE.
- cell_position  input  2*N*N  board state. Cell i occupies bits [2i+1:2i]. 00 = empty, 01 = player, 10 = AI, 11 = invalid (treated as occupied).
- ai_tick  output  IDXW  chosen cell index. Holds its value until the next done.
- done  output  1  one-cycle pulse when ai_tick, best_score and no_move are valid.
- busy  output  1  high from the cycle after start is accepted until done.
- no_move  output  1  valid with done; high when the board has no empty cell.
- best_score  output  4  score of the chosen move. Valid with done.

Behaviour:
- Reset (async, active-low): FSM goes to IDLE. ai_tick, done, busy, no_move and best_score all reset to 0. Scan index, latched board and running best all clear. Reset asserted mid-scan aborts the scan; no done is issued.
- FSM states: IDLE, SCAN, DONE.
- IDLE with start=1:
  - Latch cell_position into the internal board.
  - Clear scan index to 0, best_score to 0 and the found flag.
  - Go to SCAN; busy rises next cycle.
- SCAN: evaluate cell idx each cycle.
  - Occupied cell (any code other than 00): score 0, never selected.
  - Empty cell: score = 1 (base) + 8 if AI wins + 4 if AI blocks + 2 if centre + 1 if corner.
  - Win: AI placed at idx makes every cell of some line through idx (row, column, main diagonal if on it, anti-diagonal if on it) equal 10.
  - Block: every other cell of some line through idx equals 01.
  - Win and block may both apply.
  - Centre exists only for odd N, at index (N*N-1)/2.
  - Corners are indices 0, N-1, N*N-N and N*N-1.
  - Maximum score is 15 (centre and corner are exclusive for N >= 3), so no overflow.
  - Update rule: if score > running best, replace best and index and set found. Ties keep the lower index.
  - At idx = N*N-1, go to DONE. No early exit.
- DONE:
  - Pulse done for one cycle and drop busy.
  - If found: ai_tick = best index, best_score = best, no_move = 0.
  - If not found: ai_tick = 0, best_score = 0, no_move = 1.
  - Return to IDLE.
- Latency: done asserts exactly N*N+1 cycles after the start-accept edge (10 for N=3).
- start while busy or in DONE is ignored and not queued.
- cell_position changes during SCAN are ignored because the board is latched.
- start and reset released together: reset wins.

Optional Feature:
AI_TIEBREAK_LFSR_EN
- Defined:
  - An 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every clock.
  - On an equal, non-zero score in SCAN, replace best when lfsr[0]=1.
- Undefined: no LFSR; ties keep the lowest index (deterministic).
- All other behaviour and latency are identical in both builds.

Decomposition:
Package ai_agent_pkg holds:
- cell codes CELL_EMPTY, CELL_PLAYER, CELL_AI;
- score weights W_BASE=1, W_WIN=8, W_BLOCK=4, W_CENTER=2, W_CORNER=1;
- state enum typedef;
- LFSR seed and taps.

One natural sub-module, ai_cell_eval: combinational; takes the board and idx, returns the 4-bit score. It handles line extraction, the win/block check and the centre/corner test. The top level keeps the FSM, latching and best tracking.

Test Plan:
1. N=3, empty board, start pulse -> done at cycle 10; ai_tick=4, best_score=3, no_move=0.
2. AI at 0,1 and player at 3,4 -> ai_tick=2, best_score=10 (win+corner+base). Cell 5 (score 5) is not chosen.
3. Player at 0,1 and AI at 4 -> ai_tick=2, best_score=6 (block+corner+base).
4. Full board with no 00 cells -> done at cycle 10; no_move=1, ai_tick=0, best_score=0. Start re-pulsed at cycle 3 of this scan -> no extra done.
5. rst low at scan cycle 5, then released, then start on an empty board -> no done from the aborted scan; the fresh decision arrives 10 cycles later with ai_tick=4.
6. N=4, empty board -> done at cycle 17; ai_tick=0, best_score=2. Repeat with AI_TIEBREAK_LFSR_EN defined: ai_tick is in {0,3,12,15} and best_score=2.
